// File: rtl/vector_unit_sequencer_pkg.sv
// Shared definitions for the vector unit sequencer.
//   vseq_state_e : sequencer state encoding (IDLE / READ / DRAIN)
//   MAX_VL       : largest vector length the register file holds
//   VREG_W       : vector register index width
package vector_unit_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } vseq_state_e;

   localparam int MAX_VL = 64;
   localparam int VREG_W = 3;

endpackage

// File: rtl/vseq_valid_pipe.sv
// LAT-deep 1-bit valid shift register that mirrors the functional unit's
// pipeline, so the sequencer knows when each element result emerges.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rd_fire     : an element enters the unit this cycle
//   wr_fire     : the element entered LAT cycles ago is valid at the unit output
//   in_flight   : some element is still inside the pipe after the coming edge
module vseq_valid_pipe #(
   parameter int LAT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rd_fire,
   output logic wr_fire,
   output logic in_flight
);

   logic [LAT-1:0] sr_q;
   logic [LAT-1:0] sr_d;

   generate
      if (LAT == 1) begin : g_single
         assign sr_d = rd_fire;
      end else begin : g_chain
         assign sr_d = {sr_q[LAT-2:0], rd_fire};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign wr_fire   = sr_q[LAT-1];
   // Looks at the next contents: the element leaving this cycle does not count.
   assign in_flight = |sr_d;

endmodule

// File: rtl/vector_unit_sequencer.sv
// Issue and element sequencer for a fixed-latency pipelined vector unit.
// Accepts one instruction at a time, steps source element reads (stalling
// on i_src_ready for chaining), tracks elements through the unit latency and
// produces in-order write-back strobes plus busy/done status.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_start         : issue request (held by requester until acked)
//   i_i, i_j, i_k   : destination vreg, source vreg, operation select
//   i_vl            : vector length at issue (clamped to 64)
//   i_src_ready     : source element at o_rd_elem is available
//   o_issue_ack     : issue accepted this cycle (combinational)
//   o_busy          : instruction in progress
//   o_rd_en         : read source element this cycle (combinational)
//   o_rd_vreg/elem  : source register and element index
//   o_op            : latched operation select
//   o_wr_en         : unit result valid, write it back
//   o_wr_vreg/elem  : destination register and element index
//   o_done          : one-cycle pulse after the last write-back
module vector_unit_sequencer
   import vector_unit_sequencer_pkg::*;
#(
   parameter int LAT    = 4,
   parameter int VL_W   = 7,
   parameter int ELEM_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [2:0]        i_i,
   input  logic [2:0]        i_j,
   input  logic [2:0]        i_k,
   input  logic [VL_W-1:0]   i_vl,
   input  logic              i_src_ready,
   output logic              o_issue_ack,
   output logic              o_busy,
   output logic              o_rd_en,
   output logic [2:0]        o_rd_vreg,
   output logic [ELEM_W-1:0] o_rd_elem,
   output logic [2:0]        o_op,
   output logic              o_wr_en,
   output logic [2:0]        o_wr_vreg,
   output logic [ELEM_W-1:0] o_wr_elem,
   output logic              o_done
);

   // One extra bit so a full length of 64 is representable and compares cleanly.
   localparam int CNT_W = ELEM_W + 1;

   function automatic logic [CNT_W-1:0] clamp_len(input logic [VL_W-1:0] vl);
      if (int'(vl) > MAX_VL) return CNT_W'(MAX_VL);
      return CNT_W'(vl);
   endfunction

   vseq_state_e       state_q, state_d;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  rd_cnt_q;
   logic [CNT_W-1:0]  wr_cnt_q;
   logic [VREG_W-1:0] dst_q, src_q, op_q;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  eff_len;
   logic              rd_last;
   logic              wr_fire;
   logic              in_flight;

   assign eff_len     = clamp_len(i_vl);
   assign o_issue_ack = i_start & (state_q == IDLE);
   assign o_rd_en     = (state_q == READ) & i_src_ready;
   assign rd_last     = o_rd_en & ((rd_cnt_q + CNT_W'(1)) == len_q);

   vseq_valid_pipe #(.LAT(LAT)) u_valid_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_fire   (o_rd_en),
      .wr_fire   (wr_fire),
      .in_flight (in_flight)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (o_issue_ack) state_d = (eff_len == '0) ? DRAIN : READ;
         end
         READ: begin
            if (rd_last) state_d = DRAIN;
         end
         DRAIN: begin
            // done is registered: raise it once the final element leaves,
            // and drop back to IDLE on the edge that ends the done pulse.
            if (done_q)          state_d = IDLE;
            else if (!in_flight) done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         dst_q    <= '0;
         src_q    <= '0;
         op_q     <= '0;
      end else if (o_issue_ack) begin
         len_q    <= eff_len;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         dst_q    <= i_i;
         src_q    <= i_j;
         op_q     <= i_k;
      end else begin
         if (o_rd_en) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
         if (wr_fire) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
   end

   assign o_busy    = (state_q != IDLE);
   assign o_rd_vreg = src_q;
   assign o_rd_elem = rd_cnt_q[ELEM_W-1:0];
   assign o_op      = op_q;
   assign o_wr_en   = wr_fire;
   assign o_wr_vreg = dst_q;
   assign o_wr_elem = wr_cnt_q[ELEM_W-1:0];
   assign o_done    = done_q;

endmodule
